// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the 5-stage RV32I core: captures decoded operands and
// control, detects load-use hazards, inserts bubbles and counts load-use stall cycles.
module id_ex_stage_reg #(
  parameter int          XLEN        = 32,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
  parameter int          STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            IF_ID_Instruction,
  input  logic [XLEN-1:0]        IF_ID_PC,
  input  logic [XLEN-1:0]        ID_ReadData1,
  input  logic [XLEN-1:0]        ID_ReadData2,
  input  logic [XLEN-1:0]        ID_Imm,
  input  logic [8:0]             ID_Ctrl,
  input  logic                   Flush,
  input  logic                   Hold,
  output logic [31:0]            ID_EX_Instruction,
  output logic [XLEN-1:0]        ID_EX_PC,
  output logic [XLEN-1:0]        ID_EX_ReadData1,
  output logic [XLEN-1:0]        ID_EX_ReadData2,
  output logic [XLEN-1:0]        ID_EX_Imm,
  output logic [8:0]             ID_EX_Ctrl,
  output logic [4:0]             ID_EX_RegisterA,
  output logic [4:0]             ID_EX_RegisterB,
  output logic [4:0]             ID_EX_Rd,
  output logic                   ID_EX_Valid,
  output logic                   LoadUseStall,
  output logic [STALL_CNT_W-1:0] StallCount
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam int         CTRL_MEMREAD = 7;
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]            instr_reg;
  logic [XLEN-1:0]        pc_reg;
  logic [XLEN-1:0]        rd1_reg;
  logic [XLEN-1:0]        rd2_reg;
  logic [XLEN-1:0]        imm_reg;
  logic [8:0]             ctrl_reg;
  logic [4:0]             reg_a_reg;
  logic [4:0]             reg_b_reg;
  logic [4:0]             rd_reg;
  logic                   valid_reg;
  logic [STALL_CNT_W-1:0] stall_cnt_reg;

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       rs1_used;
  logic       rs2_used;
  logic       no_rd;
  logic       hazard;

  assign opcode = IF_ID_Instruction[6:0];
  assign rs1    = IF_ID_Instruction[19:15];
  assign rs2    = IF_ID_Instruction[24:20];

  always_comb begin
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    no_rd    = 1'b0;
    if (opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL)
      rs1_used = 1'b0;
    if (opcode == OP_R || opcode == OP_STORE || opcode == OP_BRANCH)
      rs2_used = 1'b1;
    if (opcode == OP_STORE || opcode == OP_BRANCH)
      no_rd = 1'b1;
  end

  assign hazard = valid_reg & ctrl_reg[CTRL_MEMREAD] & (rd_reg != 5'd0) &
                  ((rs1_used & (rs1 == rd_reg)) | (rs2_used & (rs2 == rd_reg)));

  assign LoadUseStall = hazard & ~Flush & ~Hold;

  // Flush beats Hold; Hold freezes everything; a hazard loads a bubble and IF/ID replays.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_reg <= NOP_INSTR;
      pc_reg    <= '0;
      rd1_reg   <= '0;
      rd2_reg   <= '0;
      imm_reg   <= '0;
      ctrl_reg  <= '0;
      reg_a_reg <= '0;
      reg_b_reg <= '0;
      rd_reg    <= '0;
      valid_reg <= 1'b0;
    end else if (Flush || (!Hold && hazard)) begin
      instr_reg <= NOP_INSTR;
      pc_reg    <= '0;
      rd1_reg   <= '0;
      rd2_reg   <= '0;
      imm_reg   <= '0;
      ctrl_reg  <= '0;
      reg_a_reg <= '0;
      reg_b_reg <= '0;
      rd_reg    <= '0;
      valid_reg <= 1'b0;
    end else if (!Hold) begin
      instr_reg <= IF_ID_Instruction;
      pc_reg    <= IF_ID_PC;
      rd1_reg   <= ID_ReadData1;
      rd2_reg   <= ID_ReadData2;
      imm_reg   <= ID_Imm;
      ctrl_reg  <= ID_Ctrl;
      reg_a_reg <= rs1_used ? rs1 : 5'd0;
      reg_b_reg <= rs2_used ? rs2 : 5'd0;
      rd_reg    <= no_rd ? 5'd0 : IF_ID_Instruction[11:7];
      valid_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_reg <= '0;
    else if (LoadUseStall && (stall_cnt_reg != '1))
      stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
  end

  assign ID_EX_Instruction = instr_reg;
  assign ID_EX_PC          = pc_reg;
  assign ID_EX_ReadData1   = rd1_reg;
  assign ID_EX_ReadData2   = rd2_reg;
  assign ID_EX_Imm         = imm_reg;
  assign ID_EX_Ctrl        = ctrl_reg;
  assign ID_EX_RegisterA   = reg_a_reg;
  assign ID_EX_RegisterB   = reg_b_reg;
  assign ID_EX_Rd          = rd_reg;
  assign ID_EX_Valid       = valid_reg;
  assign StallCount        = stall_cnt_reg;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: a driver issues instructions and pushes the
// expected EX-stage contents; monitors compare registered outputs and LoadUseStall.
module tb_id_ex_stage_reg;

  localparam int CNT_W = 8;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic [31:0]      rd1;
    logic [31:0]      rd2;
    logic [31:0]      imm;
    logic [8:0]       ctrl;
    logic [4:0]       ra;
    logic [4:0]       rb;
    logic [4:0]       rd;
    logic             valid;
    logic [CNT_W-1:0] cnt;
  } ex_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      if_instr = '0;
  logic [31:0]      if_pc = '0;
  logic [31:0]      rdata1 = '0;
  logic [31:0]      rdata2 = '0;
  logic [31:0]      imm = '0;
  logic [8:0]       ctrl = '0;
  logic             flush = 1'b0;
  logic             hold = 1'b0;
  logic [31:0]      ex_instr;
  logic [31:0]      ex_pc;
  logic [31:0]      ex_rd1;
  logic [31:0]      ex_rd2;
  logic [31:0]      ex_imm;
  logic [8:0]       ex_ctrl;
  logic [4:0]       ex_ra;
  logic [4:0]       ex_rb;
  logic [4:0]       ex_rd;
  logic             ex_valid;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  int n_cmp = 0;
  int n_bad = 0;

  ex_t  m;
  ex_t  exp_q[$];
  logic stall_q[$];
  ex_t  act;

  assign act = {ex_instr, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_ctrl, ex_ra, ex_rb, ex_rd,
                ex_valid, stall_count};

  id_ex_stage_reg #(.XLEN(32), .NOP_INSTR(32'h0000_0013), .STALL_CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_Instruction(if_instr), .IF_ID_PC(if_pc),
    .ID_ReadData1(rdata1), .ID_ReadData2(rdata2), .ID_Imm(imm), .ID_Ctrl(ctrl),
    .Flush(flush), .Hold(hold),
    .ID_EX_Instruction(ex_instr), .ID_EX_PC(ex_pc),
    .ID_EX_ReadData1(ex_rd1), .ID_EX_ReadData2(ex_rd2), .ID_EX_Imm(ex_imm),
    .ID_EX_Ctrl(ex_ctrl), .ID_EX_RegisterA(ex_ra), .ID_EX_RegisterB(ex_rb),
    .ID_EX_Rd(ex_rd), .ID_EX_Valid(ex_valid),
    .LoadUseStall(stall), .StallCount(stall_count)
  );

  always #5 clk = ~clk;

  // Reference-model helpers: bubble contents and source usage by opcode.
  function automatic ex_t bubble_of(input logic [CNT_W-1:0] cnt);
    ex_t b;
    b       = '0;
    b.instr = 32'h0000_0013;
    b.cnt   = cnt;
    return b;
  endfunction

  function automatic bit uses_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic bit uses_rs2(input logic [6:0] op);
    return (op == OP_R || op == OP_STORE || op == OP_BRANCH);
  endfunction

  function automatic bit hazard_of(input ex_t s, input logic [31:0] ins);
    logic [4:0] r1, r2;
    r1 = ins[19:15];
    r2 = ins[24:20];
    return s.valid && s.ctrl[7] && (s.rd != 5'd0) &&
           ((uses_rs1(ins[6:0]) && r1 == s.rd) || (uses_rs2(ins[6:0]) && r2 == s.rd));
  endfunction

  function automatic logic [31:0] enc(input logic [6:0] op, input int rd, input int rs1,
                                      input int rs2, input logic [11:0] im);
    logic [31:0] w;
    w        = {im[11:5], rs2[4:0], rs1[4:0], 3'b010, rd[4:0], op};
    return w;
  endfunction

  // One ID-stage cycle: drive inputs, predict LoadUseStall and the next EX contents.
  task automatic step(input logic [31:0] ins, input bit fl, input bit hd, output bit consumed);
    bit hz;
    @(negedge clk);
    if_instr = ins;
    if_pc    = $urandom;
    rdata1   = $urandom;
    rdata2   = $urandom;
    imm      = $urandom;
    ctrl     = 9'($urandom);
    ctrl[7]  = (ins[6:0] == OP_LOAD);
    flush    = fl;
    hold     = hd;
    #1;
    hz = hazard_of(m, ins);
    stall_q.push_back(hz && !fl && !hd);
    if (fl) begin
      m = bubble_of(m.cnt);
    end else if (hd) begin
      m = m;
    end else if (hz) begin
      m = bubble_of((m.cnt == {CNT_W{1'b1}}) ? m.cnt : m.cnt + 1'b1);
    end else begin
      m.instr = ins;
      m.pc    = if_pc;
      m.rd1   = rdata1;
      m.rd2   = rdata2;
      m.imm   = imm;
      m.ctrl  = ctrl;
      m.ra    = uses_rs1(ins[6:0]) ? ins[19:15] : 5'd0;
      m.rb    = uses_rs2(ins[6:0]) ? ins[24:20] : 5'd0;
      m.rd    = (ins[6:0] == OP_STORE || ins[6:0] == OP_BRANCH) ? 5'd0 : ins[11:7];
      m.valid = 1'b1;
    end
    exp_q.push_back(m);
    consumed = fl || (!hd && !hz);
  endtask

  // Present an instruction until it enters EX or is flushed.
  task automatic issue(input logic [31:0] ins, input int fl_pct, input int hd_pct);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++)
      step(ins, ($urandom_range(99) < 32'(fl_pct)), ($urandom_range(99) < 32'(hd_pct)), done);
  endtask

  task automatic check_now(input string name, input ex_t want, input logic want_stall);
    n_cmp++;
    if (act !== want || stall !== want_stall) begin
      n_bad++;
      $display("FAIL %s: got regs=%h stall=%b, expected regs=%h stall=%b",
               name, act, stall, want, want_stall);
    end
  endtask

  // Assert rst_n in the middle of a cycle that presents ins; outputs must drop at once.
  task automatic reset_mid(input logic [31:0] ins);
    @(negedge clk);
    if_instr = ins;
    flush    = 1'b0;
    hold     = 1'b0;
    #1;
    stall_q.push_back(hazard_of(m, ins));
    #2;
    rst_n = 1'b0;
    #1;
    m = bubble_of('0);
    check_now("reset_mid", m, 1'b0);
    exp_q.push_back(m);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      ex_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL ex_regs t=%0t: got %h expected %h", $time, act, e);
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (stall_q.size() > 0) begin
      logic s;
      s = stall_q.pop_front();
      n_cmp++;
      if (stall !== s) begin
        n_bad++;
        $display("FAIL load_use_stall t=%0t: got %b expected %b", $time, stall, s);
      end
    end
  end

  initial begin
    logic [6:0]  ops [9];
    logic [31:0] r;
    bit          dummy;
    ops = '{OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
    rst_n = 1'b0;
    m = bubble_of('0);
    #7;
    check_now("reset_state", m, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(enc(OP_LOAD, 5, 1, 0, 12'd0), 0, 0);
    issue(enc(OP_R, 6, 5, 2, 12'd0), 0, 0);
    issue(enc(OP_LOAD, 5, 1, 0, 12'd0), 0, 0);
    issue(enc(OP_IALU, 7, 0, 1, 12'd1), 0, 0);
    issue(enc(OP_LOAD, 0, 1, 0, 12'd0), 0, 0);
    issue(enc(OP_R, 6, 0, 0, 12'd0), 0, 0);
    issue(enc(OP_LOAD, 5, 1, 0, 12'd0), 0, 0);
    issue(enc(OP_STORE, 4, 2, 5, 12'd0), 0, 0);
    issue(enc(OP_LOAD, 5, 1, 0, 12'd0), 0, 0);
    issue(enc(OP_LUI, 5, 5, 5, 12'd0), 0, 0);
    issue(enc(OP_LOAD, 5, 1, 0, 12'd0), 0, 0);
    step(enc(OP_R, 6, 5, 2, 12'd0), 1'b1, 1'b0, dummy);
    issue(enc(OP_LOAD, 5, 1, 0, 12'd0), 0, 0);
    step(enc(OP_R, 6, 5, 2, 12'd0), 1'b1, 1'b1, dummy);
    issue(enc(OP_R, 6, 1, 2, 12'd0), 0, 0);
    for (int k = 0; k < 3; k++) step(enc(OP_R, 8, 3, 4, 12'd0), 1'b0, 1'b1, dummy);
    issue(enc(OP_R, 8, 3, 4, 12'd0), 0, 0);

    for (int k = 0; k < 300; k++) begin
      issue(enc(OP_LOAD, 3, 1, 0, 12'd0), 0, 0);
      issue(enc(OP_R, 4, 3, 3, 12'd0), 0, 0);
    end

    issue(enc(OP_LOAD, 5, 1, 0, 12'd0), 0, 0);
    reset_mid(enc(OP_R, 6, 5, 2, 12'd0));

    for (int k = 0; k < 400; k++) begin
      r = $urandom;
      r[6:0]   = ops[$urandom_range(8)];
      r[11:7]  = 5'($urandom_range(3));
      r[19:15] = 5'($urandom_range(3));
      r[24:20] = 5'($urandom_range(3));
      issue(r, 8, 12);
    end

    repeat (3) @(posedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0 || stall_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending, expected 0/0", exp_q.size(), stall_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
